// File: rtl/uart_pkg.sv
// Definitions shared by the UART FIFO pointer logic: default pointer width
// and the binary-to-Gray conversion used by counters and full/empty compares.
package uart_pkg;

    localparam int PTR_W = 4;
    localparam int MAX_W = 16;

    // Works on the widest legal pointer; callers zero-extend and truncate back.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_to_bin_n.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits at and above its position.
module gray_to_bin_n #(
    parameter int n = 4
) (
    input  logic [n-1:0] i_gray,
    output logic [n-1:0] o_bin
);

    for (genvar i = 0; i < n; i++) begin : g_bit
        assign o_bin[i] = ^(i_gray >> i);
    end

endmodule

// File: rtl/gray_counter_n.sv
// n-bit up/down counter holding its value in both binary and Gray form, each
// in its own register, with a Gray-coded synchronous load and a wrap pulse.
module gray_counter_n
    import uart_pkg::*;
#(
    parameter int n       = PTR_W,
    parameter int RST_VAL = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_up_dn,
    input  logic         i_load,
    input  logic [n-1:0] i_load_g,
    output logic [n-1:0] o_bin_out,
    output logic [n-1:0] o_gray_out,
    output logic [n-1:0] o_gray_next,
    output logic         o_wrap
);

    localparam logic [n-1:0] RST_BIN  = n'(RST_VAL);
    localparam logic [n-1:0] RST_GRAY = n'(bin2gray(16'(RST_BIN)));
    localparam logic [n-1:0] ONE      = n'(1'b1);
    localparam logic [n-1:0] ZERO     = {n{1'b0}};
    localparam logic [n-1:0] ALL_ONES = {n{1'b1}};

    logic [n-1:0] r_bin;
    logic [n-1:0] r_gray;
    logic         r_wrap;

    logic [n-1:0] w_load_bin;
    logic [n-1:0] w_next_bin;
    logic [n-1:0] w_next_gray;
    logic         w_next_wrap;

    gray_to_bin_n #(
        .n(n)
    ) u_load_dec (
        .i_gray(i_load_g),
        .o_bin (w_load_bin)
    );

    // Next-state selection: load beats step beats hold.
    always_comb begin
        w_next_bin  = r_bin;
        w_next_gray = r_gray;
        w_next_wrap = 1'b0;
        if (i_load) begin
            w_next_bin  = w_load_bin;
            w_next_gray = i_load_g;
        end else if (i_en) begin
            if (i_up_dn) begin
                w_next_bin  = r_bin + ONE;
                w_next_wrap = (r_bin == ALL_ONES);
            end else begin
                w_next_bin  = r_bin - ONE;
                w_next_wrap = (r_bin == ZERO);
            end
            w_next_gray = n'(bin2gray(16'(w_next_bin)));
        end else begin
            w_next_gray = r_gray;
        end
    end

    // Counter registers; the Gray copy is stored, not decoded, so it never glitches.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bin  <= RST_BIN;
            r_gray <= RST_GRAY;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_gray;
            r_wrap <= w_next_wrap;
        end
    end

    assign o_bin_out   = r_bin;
    assign o_gray_out  = r_gray;
    assign o_gray_next = w_next_gray;
    assign o_wrap      = r_wrap;

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n: a 4-bit instance (reset value 5) for
// the directed scenarios and an 8-bit instance for a randomized sweep.
module tb_gray_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, en4, up4, ld4;
    logic [3:0] lg4, bin4, gray4, gn4;
    logic       wrap4;
    logic       rst8, en8, up8, ld8;
    logic [7:0] lg8, bin8, gray8, gn8;
    logic       wrap8;

    gray_counter_n #(.n(4), .RST_VAL(5)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_en(en4), .i_up_dn(up4), .i_load(ld4),
        .i_load_g(lg4), .o_bin_out(bin4), .o_gray_out(gray4),
        .o_gray_next(gn4), .o_wrap(wrap4)
    );

    gray_counter_n #(.n(8), .RST_VAL(0)) dut8 (
        .i_clk(clk), .i_rst(rst8), .i_en(en8), .i_up_dn(up8), .i_load(ld8),
        .i_load_g(lg8), .o_bin_out(bin8), .o_gray_out(gray8),
        .o_gray_next(gn8), .o_wrap(wrap8)
    );

    typedef struct {
        int bin;
        int gray;
        bit wrap;
        bit step;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    int   checks   = 0;
    int   failures = 0;
    int   m4;
    int   m8;

    function automatic int g_of(int b);
        return b ^ (b >> 1);
    endfunction

    // Inverse by search: the binary value whose Gray code matches.
    function automatic int b_of(int w, int g);
        for (int b = 0; b < (1 << w); b++) begin
            if (g_of(b) == g) return b;
        end
        return -1;
    endfunction

    function automatic exp_t model(int w, int cur, bit en, bit up, bit ld, int lg);
        exp_t e;
        int   top = 1 << w;
        e.step = 1'b0;
        e.wrap = 1'b0;
        if (ld) begin
            e.bin = b_of(w, lg);
        end else if (en) begin
            e.step = 1'b1;
            if (up) begin
                e.bin  = (cur + 1) % top;
                e.wrap = (cur == top - 1);
            end else begin
                e.bin  = (cur + top - 1) % top;
                e.wrap = (cur == 0);
            end
        end else begin
            e.bin = cur;
        end
        e.gray = g_of(e.bin);
        return e;
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic cyc4(bit en, bit up, bit ld, int lg);
        exp_t e;
        en4 = en; up4 = up; ld4 = ld; lg4 = 4'(lg);
        #1;
        e = model(4, m4, en, up, ld, lg);
        check("gray_next4", int'(gn4), e.gray);
        q4.push_back(e);
        m4 = e.bin;
        @(negedge clk);
    endtask

    task automatic cyc8(bit en, bit up, bit ld, int lg);
        exp_t e;
        en8 = en; up8 = up; ld8 = ld; lg8 = 8'(lg);
        #1;
        e = model(8, m8, en, up, ld, lg);
        check("gray_next8", int'(gn8), e.gray);
        q8.push_back(e);
        m8 = e.bin;
        @(negedge clk);
    endtask

    // Idle dut4, let the monitor drain, then pulse reset between edges.
    task automatic mid_reset4(string tag);
        en4 = 1'b0; ld4 = 1'b0;
        @(posedge clk); #2;
        rst4 = 1'b1;
        #1;
        check({tag, "_bin"}, int'(bin4), 5);
        check({tag, "_gray"}, int'(gray4), 7);
        check({tag, "_wrap"}, int'(wrap4), 0);
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        m4 = 5;
    endtask

    // Monitor: every cycle, pop one expected result per instance if present.
    initial begin
        logic [3:0] prev4;
        logic [7:0] prev8;
        exp_t       e;
        prev4 = '0;
        prev8 = '0;
        forever begin
            @(posedge clk); #1;
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check("bin4", int'(bin4), e.bin);
                check("gray4", int'(gray4), e.gray);
                check("wrap4", int'(wrap4), int'(e.wrap));
                if (e.step) check("onebit4", $countones(gray4 ^ prev4), 1);
            end
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check("bin8", int'(bin8), e.bin);
                check("gray8", int'(gray8), e.gray);
                check("wrap8", int'(wrap8), int'(e.wrap));
                if (e.step) check("onebit8", $countones(gray8 ^ prev8), 1);
            end
            prev4 = gray4;
            prev8 = gray8;
        end
    end

    initial begin
        rst4 = 1'b1; en4 = 1'b0; up4 = 1'b0; ld4 = 1'b0; lg4 = 4'h0;
        rst8 = 1'b1; en8 = 1'b0; up8 = 1'b0; ld8 = 1'b0; lg8 = 8'h0;
        m4 = 5;
        m8 = 0;
        @(negedge clk);
        check("rst_bin4", int'(bin4), 5);
        check("rst_gray4", int'(gray4), 7);
        check("rst_wrap4", int'(wrap4), 0);
        check("rst_bin8", int'(bin8), 0);
        rst4 = 1'b0;
        rst8 = 1'b0;
        @(negedge clk);

        cyc4(1, 1, 0, 0);
        cyc4(1, 1, 0, 0);
        mid_reset4("async_rst");

        // Load zero, then a full up lap through the 15->0 wrap.
        cyc4(0, 0, 1, 0);
        for (int i = 0; i < 16; i++) cyc4(1, 1, 0, 0);

        // Underflow then immediate reversal back over the boundary.
        cyc4(1, 0, 0, 0);
        cyc4(1, 1, 0, 0);

        // Load Gray 2 (bin 3), then load 4'hC with en/up also active.
        cyc4(0, 0, 1, 2);
        cyc4(1, 1, 1, 12);

        for (int i = 0; i < 3; i++) cyc4(0, 0, 0, 0);

        cyc4(1, 1, 0, 0);
        mid_reset4("mid_rst");
        cyc4(1, 1, 0, 0);
        cyc4(1, 1, 0, 0);

        for (int i = 0; i < 40; i++)
            cyc4($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15));
        en4 = 1'b0; ld4 = 1'b0;

        for (int i = 0; i < 300; i++)
            cyc8($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 255));
        en8 = 1'b0; ld8 = 1'b0;

        @(posedge clk); #3;
        check("drain4", q4.size(), 0);
        check("drain8", q8.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_counter_n.md
Name: gray_counter_n

Overview:
- Parametrised n-bit up/down counter that holds its state in both binary and Gray form.
- Both forms are registered.
- Intended as the read/write pointer generator for the UART TX/RX FIFOs.
- gray_out changes exactly one bit per count step, so it is safe to hand to a 2-flop synchroniser in another domain. bin_out is used for local addressing.

Parameters:
- n, 4, counter width in bits; legal range 2..16.
- RST_VAL, 0, binary reset value of the counter; must be < 2**n.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance counter one step this cycle.
- up_dn  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load of load_g; overrides en.
- load_g  input  n  Gray-coded value to load.
- bin_out  output  n  registered binary count.
- gray_out  output  n  registered Gray count, always equal to gray(bin_out).
- gray_next  output  n  combinational Gray value that will be registered at the next clk edge for the current inputs.
- wrap  output  1  registered one-cycle pulse; high in the cycle after a step crossed the 2**n boundary.

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-count):
  - bin_out = RST_VAL
  - gray_out = RST_VAL ^ (RST_VAL >> 1)
  - wrap = 0
- Release of rst takes effect on the first rising clk with rst=0. No extra pipeline flush is needed.
- Gray rule: g[i] = b[i] ^ b[i+1] for i < n-1; g[n-1] = b[n-1].
- Inverse rule for load: b[n-1] = g[n-1]; b[i] = b[i+1] ^ g[i], evaluated MSB down to LSB.
- Priority per rising clk edge: load > en > hold.
- Load (load=1):
  - bin_out <= gray2bin(load_g); gray_out <= load_g; wrap <= 0.
  - en and up_dn are ignored in that cycle.
- Step (load=0, en=1):
  - next_bin = bin_out + 1 (up_dn=1) or bin_out - 1 (up_dn=0), modulo 2**n with silent wrap.
  - gray_out <= gray(next_bin).
  - wrap <= 1 if (up_dn=1 and bin_out = 2**n-1) or (up_dn=0 and bin_out = 0); else wrap <= 0.
- Hold (load=0, en=0): bin_out and gray_out unchanged; wrap <= 0.
- Latency: one cycle from en/load to bin_out/gray_out. gray_next has zero latency (combinational) and equals gray_out whenever load=0 and en=0.
- gray_out is driven straight from its own flop register, never from a combinational decode of bin_out, so it cannot glitch.
- Direction may change on any cycle. A reversal also changes gray_out by exactly one bit.
- All arithmetic is n bits wide with no carry-out port. wrap is the only indication of overflow or underflow.
- No other state; there is no state machine beyond the counter registers and the wrap flop.

Decomposition:
- Shared package uart_pkg:
  - default pointer width constant PTR_W = 4.
  - function bin2gray(n-bit), used by this block and the FIFO full/empty compare logic.
- Sub-module gray_to_bin_n (parameter n): combinational prefix-XOR decoder for the load path. It is reused by the FIFO's synchronised-pointer decode.
- Binary-to-Gray conversion stays inline via the package function.

Test Plan:
- Reset: n=4, RST_VAL=5, assert rst asynchronously between edges -> bin_out=5 and gray_out=4'h7 immediately, before the next clk; wrap=0.
- Up count: RST_VAL=0, en=1, up_dn=1 for 16 cycles.
  - Required gray_out sequence: 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - wrap=1 only in the cycle after the 15->0 step.
  - Scoreboard checks popcount(gray_out ^ previous gray_out) = 1 on every step.
- Down/reversal: from bin 0, en=1, up_dn=0 -> bin_out=15, gray_out=4'h8, wrap=1. Next cycle up_dn=1 -> bin_out=0, gray_out=0, wrap=1.
- Load priority: bin=3, load=1, load_g=4'hC, en=1, up_dn=1 in the same cycle -> bin_out=8, gray_out=4'hC, wrap=0. gray_next equals 4'hC during that cycle.
- Hold and mid-operation reset: en=0 for 3 cycles -> outputs stable and wrap=0. Then rst pulse in the middle of an up count at bin 9 -> bin_out=RST_VAL immediately, and counting resumes from RST_VAL on the first edge after release.
- Width sweep: n=8, 300 random cycles of en/up_dn/load against a reference model -> bin_out and gray_out match the model exactly; one-bit-change property holds on every non-load step.
